i2s_serializer: RTL and testbench
=================================

Name: i2s_serializer

Overview:
- Downstream stage of the 4-channel mixer: accepts one stereo 16-bit PCM frame per audio frame over a valid/ready handshake.
- Serializes each accepted frame onto the codec's I2S pins (frame_clk, bit_clk, sdata) in Philips format: 64 bit clocks per frame, 32-bit slots, 16-bit data.
- Single-entry holding register decouples the mixer from the frame timing.
- An empty holding register at frame start is an underrun; the previous frame is replayed.

Parameters:
- CLK_DIV, 4, clk cycles per bit_clk period; even, >= 2 (12.288 MHz / 4 = 3.072 MHz = 48 kHz x 64).
- SAMPLE_W, 16, PCM sample width; must be <= 31.

Ports:
- clk  in  1  system (slow audio) clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- sample_left  in  SAMPLE_W  left PCM sample, two's complement.
- sample_right  in  SAMPLE_W  right PCM sample.
- sample_valid  in  1  producer has a frame on sample_left/right.
- sample_ready  out  1  holding register empty; transfer when valid && ready.
- frame_clk  out  1  I2S word select: 0 = left slot, 1 = right slot.
- bit_clk  out  1  I2S serial clock.
- sdata  out  1  I2S serial data, changes only on bit_clk falling edge.
- underrun  out  1  one-clk pulse when a frame starts with the holding register empty.

Behaviour:
- Reset values (while reset = 0):
  - div_cnt = 0, bit_idx = 63, hold_full = 0.
  - hold regs and frame regs = 0.
  - Outputs: bit_clk = 0, frame_clk = 0, sdata = 0, underrun = 0, sample_ready = 1.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - bit_clk (registered) = 1 while div_cnt in [CLK_DIV/2, CLK_DIV-1], else 0.
  - fall strobe = the cycle div_cnt wraps to 0; bit_idx advances mod 64 on that edge.
  - The first fall occurs CLK_DIV cycles after reset release and enters bit_idx 0.
- Registered outputs, updated on each fall strobe to the value for the new bit_idx k:
  - frame_clk = 0 for k 0..31, 1 for k 32..63.
  - sdata = left[SAMPLE_W-k] for k 1..SAMPLE_W (MSB first, one-bit I2S delay).
  - sdata = right[SAMPLE_W-(k-32)] for k 33..32+SAMPLE_W.
  - sdata = 0 for every other k.
- Handshake:
  - sample_ready = !hold_full.
  - On valid && ready: hold regs capture both samples; hold_full is set the next cycle.
  - Data must be stable only in the accepting cycle.
- Frame load, on the fall strobe entering k = 0:
  - If hold_full: frame regs <= hold regs, hold_full <= 0. sample_ready rises the following cycle, never the same cycle.
  - If not hold_full: frame regs unchanged (repeat last frame), underrun = 1 for exactly that cycle.
  - Frame regs change only at k = 0, so left and right always come from the same frame.
- Simultaneous events:
  - Transfer and frame-load empty in the same cycle is impossible: a transfer needs hold_full = 0, a load needs hold_full = 1.
  - A transfer in the very cycle of an underrun load is accepted into hold and used next frame.
- sample_valid high with ready low: no effect; producer holds data.
- Reset asserted mid-frame: immediate return to reset values; no partial frame completes.
- Latency: a frame accepted before a frame start has its left MSB on sdata at the next k = 1 fall, i.e. CLK_DIV clk after that frame start.

Optional Feature:
- Macro: I2S_UNDERRUN_CNT_EN.
- Defined:
  - Adds output underrun_cnt [15:0], reset 0.
  - Increments on each underrun pulse and saturates at 16'hFFFF.
  - Clears on a transfer when the new input clr_underrun_cnt = 1; a clear in the same cycle as an underrun wins and yields 0.
- Undefined: no extra ports or counter; all other behaviour is identical.

Decomposition:
- Package apu_audio_pkg holds:
  - SLOT_W = 32, FRAME_BITS = 64.
  - typedef sample_t (logic signed [15:0]).
  - typedef stereo_t struct {sample_t left, right}.
- Sub-module i2s_clk_gen: the divider, producing bit_clk, the fall strobe and bit_idx. The serializer instantiates it and owns the handshake, hold/frame registers and data mux.

Test Plan:
- Reset release, CLK_DIV = 4, no valid -> first fall at clk 4; frame_clk toggles every 128 clk; underrun pulses every 256 clk; sdata stays 0.
- Send left = 16'hA5C3, right = 16'h0F01 before frame start -> sdata bits 1..16 = A5C3 MSB first with frame_clk = 0; bits 33..48 = 0F01 with frame_clk = 1; every other bit 0; no underrun for that frame.
- Producer holds valid high continuously -> exactly one transfer per 256 clk; ready low between transfer and the next k = 0 load; no underrun after the first frame.
- Stop sending after frame 16'h1234/16'h8000 -> next frames replay 1234/8000; one underrun pulse per frame.
- Assert reset at bit_idx 40 mid-right-slot -> all outputs go to 0 and ready to 1 immediately; the frame restarts cleanly CLK_DIV clk after release.
- With I2S_UNDERRUN_CNT_EN: 3 starved frames -> underrun_cnt = 3; transfer with clr_underrun_cnt = 1 -> 0; force count 16'hFFFF plus one underrun -> stays FFFF.

Source files
------------

// File: rtl/apu_audio_pkg.sv
// Shared audio-path types and I2S frame geometry.
// Frame is two 32-bit slots; samples are left-justified after the one-bit I2S delay.
package apu_audio_pkg;

    localparam int SLOT_W     = 32;
    localparam int FRAME_BITS = 64;
    localparam int IDX_W      = $clog2(FRAME_BITS);

    typedef logic signed [15:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock divider: bit_clk, fall strobe and bit index within the 64-bit frame.
// Latency: bit_clk registered from the divider; fall_o is high the cycle before the falling edge lands.
// Backpressure: none, free-running.
module i2s_clk_gen
    import apu_audio_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    output logic             bit_clk_o,
    output logic             fall_o,
    output logic [IDX_W-1:0] bit_idx_o
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0] bit_idx_q;
    logic             bit_clk_q;

    // fall_o marks the edge on which div_cnt wraps to 0 and bit_clk drops.
    assign fall_o    = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign div_cnt_d = fall_o ? '0 : div_cnt_q + DIV_W'(1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_cnt_q <= '0;
            bit_idx_q <= '1;
            bit_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_clk_q <= (div_cnt_d >= DIV_W'(CLK_DIV / 2));
            if (fall_o) begin
                bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
        end
    end

    assign bit_clk_o = bit_clk_q;
    assign bit_idx_o = bit_idx_q;

endmodule

// File: rtl/i2s_serializer.sv
// Stereo PCM to Philips I2S serializer with single-entry hold register; optional I2S_UNDERRUN_CNT_EN counter.
// Latency: left MSB appears CLK_DIV clk after the frame start that loads the frame.
// Backpressure: sample_ready low while hold register full; empty hold at frame start replays last frame.
module i2s_serializer
    import apu_audio_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_left,
    input  logic [SAMPLE_W-1:0] sample_right,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                frame_clk,
    output logic                bit_clk,
    output logic                sdata,
    output logic                underrun
`ifdef I2S_UNDERRUN_CNT_EN
    ,
    input  logic                clr_underrun_cnt,
    output logic [15:0]         underrun_cnt
`endif
);

    localparam int SEL_W = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;

    logic             fall;
    logic [IDX_W-1:0] bit_idx;
    logic [IDX_W-1:0] k_nxt;
    logic [IDX_W-1:0] slot_pos;
    logic             slot_right;
    logic [SEL_W-1:0] bit_sel;
    logic             sdata_d;
    logic             xfer;
    logic             frame_start;

    logic [SAMPLE_W-1:0] hold_l_q, hold_r_q;
    logic [SAMPLE_W-1:0] frame_l_q, frame_r_q;
    logic                hold_full_q;
    logic                frame_clk_q;
    logic                sdata_q;
    logic                underrun_q;

    i2s_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk_i     (clk),
        .rst_n_i   (reset),
        .bit_clk_o (bit_clk),
        .fall_o    (fall),
        .bit_idx_o (bit_idx)
    );

    assign xfer        = sample_valid && !hold_full_q;
    assign k_nxt       = bit_idx + IDX_W'(1);
    assign frame_start = fall && (k_nxt == '0);

    // Slot position 1..SAMPLE_W carries the sample MSB first; position 0 is the I2S delay bit.
    always_comb begin
        slot_right = (k_nxt >= IDX_W'(SLOT_W));
        slot_pos   = slot_right ? (k_nxt - IDX_W'(SLOT_W)) : k_nxt;
        bit_sel    = SEL_W'(SAMPLE_W - int'(slot_pos));
        sdata_d    = 1'b0;
        if ((slot_pos >= IDX_W'(1)) && (slot_pos <= IDX_W'(SAMPLE_W))) begin
            sdata_d = slot_right ? frame_r_q[bit_sel] : frame_l_q[bit_sel];
        end
    end

    // A transfer needs an empty hold and a load needs a full one, so they never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            hold_full_q <= 1'b0;
            frame_l_q   <= '0;
            frame_r_q   <= '0;
            frame_clk_q <= 1'b0;
            sdata_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (xfer) begin
                hold_l_q    <= sample_left;
                hold_r_q    <= sample_right;
                hold_full_q <= 1'b1;
            end
            if (frame_start) begin
                if (hold_full_q) begin
                    frame_l_q   <= hold_l_q;
                    frame_r_q   <= hold_r_q;
                    hold_full_q <= 1'b0;
                end else begin
                    underrun_q  <= 1'b1;
                end
            end
            if (fall) begin
                frame_clk_q <= slot_right;
                sdata_q     <= sdata_d;
            end
        end
    end

    assign sample_ready = !hold_full_q;
    assign frame_clk    = frame_clk_q;
    assign sdata        = sdata_q;
    assign underrun     = underrun_q;

`ifdef I2S_UNDERRUN_CNT_EN
    logic [15:0] ur_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ur_cnt_q <= '0;
        end else if (xfer && clr_underrun_cnt) begin
            ur_cnt_q <= '0;
        end else if (underrun_q && (ur_cnt_q != 16'hFFFF)) begin
            ur_cnt_q <= ur_cnt_q + 16'd1;
        end
    end

    assign underrun_cnt = ur_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_serializer.sv
// Bench for i2s_serializer: reference model derives bit index from elapsed clocks since reset release.
module tb_i2s_serializer;

    localparam int CLK_DIV   = 4;
    localparam int SW        = 16;
    localparam int FRAME_CLK = CLK_DIV * 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] sample_left;
    logic [SW-1:0] sample_right;
    logic          sample_valid;
    logic          sample_ready;
    logic          frame_clk;
    logic          bit_clk;
    logic          sdata;
    logic          underrun;
`ifdef I2S_UNDERRUN_CNT_EN
    logic          clr_underrun_cnt;
    logic [15:0]   underrun_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2s_serializer #(
        .CLK_DIV  (CLK_DIV),
        .SAMPLE_W (SW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .frame_clk    (frame_clk),
        .bit_clk      (bit_clk),
        .sdata        (sdata),
        .underrun     (underrun)
`ifdef I2S_UNDERRUN_CNT_EN
        ,
        .clr_underrun_cnt (clr_underrun_cnt),
        .underrun_cnt     (underrun_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    int          c;
    bit          m_full;
    bit          m_xfer;
    bit          m_ur;
    bit          m_fc;
    bit          m_sd;
    logic [15:0] m_hl, m_hr, m_fl, m_fr;
    logic [15:0] m_cnt;
    logic [15:0] cap_l, cap_r, last_l, last_r;
    int          ur_seen;
    int          dut_xfers;

    function automatic int k_of(input int cc);
        if (cc < CLK_DIV) return 63;
        return ((cc / CLK_DIV) - 1) % 64;
    endfunction

    function automatic bit slot_bit(input logic [15:0] w, input int pos);
        if (pos >= 1 && pos <= SW) return w[SW - pos];
        return 1'b0;
    endfunction

    task automatic model_reset();
        c      = 0;
        m_full = 1'b0;
        m_xfer = 1'b0;
        m_ur   = 1'b0;
        m_fc   = 1'b0;
        m_sd   = 1'b0;
        m_hl   = '0;
        m_hr   = '0;
        m_fl   = '0;
        m_fr   = '0;
        m_cnt  = '0;
    endtask

    function automatic logic [31:0] pins();
        return 32'({sample_ready, bit_clk, frame_clk, sdata, underrun});
    endfunction

    task automatic step_in_reset();
        @(posedge clk);
        #1;
        check("rst_pins", pins(), 32'b10000);
`ifdef I2S_UNDERRUN_CNT_EN
        check("rst_cnt", 32'(underrun_cnt), 32'd0);
`endif
    endtask

    task automatic step();
        bit prev_ur;
        bit bclk_exp;
        int k;
        if (sample_valid && sample_ready) dut_xfers++;
        @(posedge clk);
        m_xfer  = sample_valid && !m_full;
        prev_ur = m_ur;
        c++;
        m_ur = 1'b0;
`ifdef I2S_UNDERRUN_CNT_EN
        if (m_xfer && clr_underrun_cnt) m_cnt = '0;
        else if (prev_ur && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
        k = k_of(c);
        if (c % CLK_DIV == 0) begin
            if (k == 0) begin
                if (m_full) begin
                    m_fl   = m_hl;
                    m_fr   = m_hr;
                    m_full = 1'b0;
                end else begin
                    m_ur = 1'b1;
                end
            end
            m_fc = (k >= 32);
            m_sd = (k < 32) ? slot_bit(m_fl, k) : slot_bit(m_fr, k - 32);
        end
        if (m_xfer) begin
            m_hl   = sample_left;
            m_hr   = sample_right;
            m_full = 1'b1;
        end
        bclk_exp = ((c % CLK_DIV) >= CLK_DIV / 2);
        #1;
        check("pins", pins(), 32'({!m_full, bclk_exp, m_fc, m_sd, m_ur}));
`ifdef I2S_UNDERRUN_CNT_EN
        check("ucnt", 32'(underrun_cnt), 32'(m_cnt));
`endif
        if (underrun) ur_seen++;
        if (c % CLK_DIV == 0) begin
            if (k >= 1 && k <= SW) begin
                cap_l = {cap_l[14:0], sdata};
                if (k == SW) last_l = cap_l;
            end
            if (k >= 33 && k <= 32 + SW) begin
                cap_r = {cap_r[14:0], sdata};
                if (k == 32 + SW) last_r = cap_r;
            end
        end
    endtask

    task automatic wait_frame_start();
        bit found;
        found = 1'b0;
        for (int i = 0; i < FRAME_CLK + CLK_DIV && !found; i++) begin
            step();
            if (c % CLK_DIV == 0 && k_of(c) == 0) found = 1'b1;
        end
        if (!found) check("frame_start_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        bit done;
        done         = 1'b0;
        sample_valid = 1'b1;
        sample_left  = l;
        sample_right = r;
        for (int i = 0; i < 2 * FRAME_CLK && !done; i++) begin
            step();
            if (m_xfer) done = 1'b1;
        end
        sample_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        sample_valid = 1'b0;
        sample_left  = '0;
        sample_right = '0;
`ifdef I2S_UNDERRUN_CNT_EN
        clr_underrun_cnt = 1'b0;
`endif
        cap_l = '0; cap_r = '0; last_l = '0; last_r = '0;
        ur_seen = 0; dut_xfers = 0;
        model_reset();
        #1;
        check("reset_pins", pins(), 32'b10000);
        repeat (3) step_in_reset();
        reset = 1'b1;

        // Idle: underrun at every frame start, sdata stays 0.
        ur_seen = 0;
        repeat (600) step();
        check("idle_underruns", 32'(ur_seen), 32'd3);
`ifdef I2S_UNDERRUN_CNT_EN
        check("cnt_three", 32'(underrun_cnt), 32'd3);
        clr_underrun_cnt = 1'b1;
        send(16'h5555, 16'hAAAA);
        clr_underrun_cnt = 1'b0;
        check("cnt_cleared", 32'(underrun_cnt), 32'd0);
`endif

        // Directed frame.
        wait_frame_start();
        send(16'hA5C3, 16'h0F01);
        ur_seen = 0;
        last_l  = '0;
        last_r  = '0;
        wait_frame_start();
        repeat (200) step();
        check("left_word", 32'(last_l), 32'h0000A5C3);
        check("right_word", 32'(last_r), 32'h00000F01);
        check("directed_no_underrun", 32'(ur_seen), 32'd0);

        // Producer always valid.
        wait_frame_start();
        ur_seen      = 0;
        dut_xfers    = 0;
        sample_valid = 1'b1;
        for (int i = 0; i < 4 * FRAME_CLK; i++) begin
            sample_left  = 16'($urandom);
            sample_right = 16'($urandom);
            step();
        end
        sample_valid = 1'b0;
        check("stream_xfers", 32'(dut_xfers), 32'd4);
        check("stream_no_underrun", 32'(ur_seen), 32'd0);

        // Starve after one frame: it replays.
        send(16'h1234, 16'h8000);
        wait_frame_start();
        ur_seen = 0;
        last_l  = '0;
        last_r  = '0;
        repeat (3 * FRAME_CLK) step();
        check("starve_underruns", 32'(ur_seen), 32'd3);
        repeat (250) step();
        check("replay_left", 32'(last_l), 32'h00001234);
        check("replay_right", 32'(last_r), 32'h00008000);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            sample_valid = ($urandom_range(0, 99) < 30);
            sample_left  = 16'($urandom);
            sample_right = 16'($urandom);
`ifdef I2S_UNDERRUN_CNT_EN
            clr_underrun_cnt = ($urandom_range(0, 9) == 0);
`endif
            step();
        end
        sample_valid = 1'b0;
`ifdef I2S_UNDERRUN_CNT_EN
        clr_underrun_cnt = 1'b0;
`endif

        // Reset mid right slot.
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < FRAME_CLK + CLK_DIV && !hit; i++) begin
                step();
                if (c % CLK_DIV == 0 && k_of(c) == 40) hit = 1'b1;
            end
            check("reach_k40", 32'(hit), 32'd1);
        end
        reset = 1'b0;
        #1;
        check("midframe_reset_pins", pins(), 32'b10000);
        model_reset();
        repeat (2) step_in_reset();
        reset = 1'b1;
        repeat (3) step();
        check("restart_bclk_high", 32'(bit_clk), 32'd1);
        step();
        check("restart_bclk_fall", 32'(bit_clk), 32'd0);
        check("restart_underrun", 32'(underrun), 32'd1);
        repeat (300) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
